mul_unit: RTL and testbench



---
 rtl/mul_unit.sv | 147 ++++++++++++++
 tb/tb_mul_unit.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mul_unit.sv
// ---------------------------------------------------------------------------
// mul_unit
//
// Iterative RV32M multiply unit (MUL, MULH, MULHSU, MULHU). It uses a radix-2
// shift-add datapath that retires one multiplier bit per cycle, so a legal
// request completes 32 cycles after it is accepted.
//
// Ports
//   clk      in   rising-edge clock
//   rst_n    in   asynchronous active-low reset
//   start    in   request strobe, accepted in IDLE or DONE
//   funct3   in   RV32M funct3 of the request (1xx = divide, treated as illegal)
//   rs1_val  in   multiplicand operand
//   rs2_val  in   multiplier operand
//   busy     out  high while the shift-add loop is running
//   done     out  one-cycle pulse, result valid in this cycle
//   result   out  product word, held until the next accepted request completes
//
// Optional feature macro
//   MUL_ZERO_BYPASS_EN : when defined, a legal request with a zero operand
//                        skips the loop and finishes the cycle after acceptance.
// ---------------------------------------------------------------------------
module mul_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] rs1_val,
  input  logic [XLEN-1:0] rs2_val,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int CW = $clog2(XLEN);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t              r_state;
  state_t              w_next;
  logic [CW-1:0]       r_cnt;
  logic [XLEN-1:0]     r_mcand;
  logic [2*XLEN-1:0]   r_prod;
  logic                r_neg;
  logic                r_hi;

  logic                w_accept;
  logic                w_legal;
  logic                w_zero;
  logic                w_skip;
  logic                w_s1;
  logic                w_s2;
  logic [XLEN-1:0]     w_mag1;
  logic [XLEN-1:0]     w_mag2;
  logic [XLEN:0]       w_sum;
  logic [2*XLEN-1:0]   w_prod_next;
  logic [2*XLEN-1:0]   w_final;

  assign w_accept = start && ((r_state == IDLE) || (r_state == DONE));
  assign w_legal  = ~funct3[2];

`ifdef MUL_ZERO_BYPASS_EN
  assign w_zero = (rs1_val == '0) || (rs2_val == '0);
`else
  assign w_zero = 1'b0;
`endif

  // Illegal encodings and (optionally) zero operands go straight to DONE
  // with a zero result.
  assign w_skip = ~w_legal | w_zero;

  // rs1 is signed for MUL/MULH/MULHSU, rs2 only for MUL/MULH. Negating
  // 0x80000000 yields 0x80000000, which read unsigned is exactly 2^31.
  assign w_s1   = rs1_val[XLEN-1] & ~(funct3[1] & funct3[0]);
  assign w_s2   = rs2_val[XLEN-1] & ~funct3[1];
  assign w_mag1 = w_s1 ? (~rs1_val + XLEN'(1)) : rs1_val;
  assign w_mag2 = w_s2 ? (~rs2_val + XLEN'(1)) : rs2_val;

  // r_prod holds {partial high half, remaining multiplier bits}; each step
  // conditionally adds the multiplicand into the high half and shifts right.
  assign w_sum       = {1'b0, r_prod[2*XLEN-1:XLEN]} + (r_prod[0] ? {1'b0, r_mcand} : '0);
  assign w_prod_next = {w_sum, r_prod[XLEN-1:1]};
  assign w_final     = r_neg ? (~w_prod_next + (2*XLEN)'(1)) : w_prod_next;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic; a request in DONE is taken back-to-back
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE, DONE: begin
        if (start) begin
          w_next = w_skip ? DONE : CALC;
        end else begin
          w_next = IDLE;
        end
      end
      CALC: begin
        if (r_cnt == '0) begin
          w_next = DONE;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  // Operand latch, shift-add iteration and result capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt   <= '0;
      r_mcand <= '0;
      r_prod  <= '0;
      r_neg   <= 1'b0;
      r_hi    <= 1'b0;
      result  <= '0;
    end else if (w_accept) begin
      r_mcand <= w_mag1;
      r_prod  <= {{XLEN{1'b0}}, w_mag2};
      r_neg   <= w_s1 ^ w_s2;
      r_hi    <= (funct3[1:0] != 2'b00);
      r_cnt   <= CW'(XLEN - 1);
      if (w_skip) begin
        result <= '0;
      end
    end else if (r_state == CALC) begin
      r_prod <= w_prod_next;
      if (r_cnt == '0) begin
        result <= r_hi ? w_final[2*XLEN-1:XLEN] : w_final[XLEN-1:0];
      end else begin
        r_cnt <= r_cnt - CW'(1);
      end
    end
  end

  assign busy = (r_state == CALC);
  assign done = (r_state == DONE);

endmodule

// File: tb/tb_mul_unit.sv
// ---------------------------------------------------------------------------
// tb_mul_unit
//
// Directed self-checking bench for mul_unit. Inputs are driven and outputs
// sampled on the falling edge. Latency is reported as k, the index of the
// accepting-edge-relative rising edge Ek after which done is seen high
// (32 for a full multiply, 0 when done follows the accepting edge directly).
// ---------------------------------------------------------------------------
module tb_mul_unit;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [2:0]  funct3;
  logic [31:0] rs1_val;
  logic [31:0] rs2_val;
  logic        busy;
  logic        done;
  logic [31:0] result;

  int nChecks = 0;
  int nFails  = 0;

`ifdef MUL_ZERO_BYPASS_EN
  localparam int ZERO_LAT  = 0;
  localparam int ZERO_BUSY = 0;
`else
  localparam int ZERO_LAT  = 32;
  localparam int ZERO_BUSY = 32;
`endif

  mul_unit #(.XLEN(32)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .funct3  (funct3),
    .rs1_val (rs1_val),
    .rs2_val (rs2_val),
    .busy    (busy),
    .done    (done),
    .result  (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present a request for one rising edge, then scramble the inputs so that
  // anything not latched at the accepting edge would show up as a bad result.
  task automatic applyStimulus(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    start   = 1'b1;
    funct3  = f;
    rs1_val = a;
    rs2_val = b;
    @(negedge clk);
    start   = 1'b0;
    funct3  = 3'b011;
    rs1_val = 32'hDEAD_BEEF;
    rs2_val = 32'h1234_5678;
  endtask

  // Wait (bounded) for done, counting busy cycles along the way.
  task automatic waitDone(input int startLat, output int lat, output int busyCnt);
    lat     = startLat;
    busyCnt = 0;
    while (done !== 1'b1 && lat < 40) begin
      if (busy === 1'b1) busyCnt++;
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    start = 1'b0;
    funct3 = 3'b000;
    rs1_val = '0;
    rs2_val = '0;
    repeat (2) @(negedge clk);
    nChecks++;
    if ({busy, done, result} !== 34'h0) begin
      nFails++;
      $display("[TB] FAIL reset_state busy=%b done=%b result=%h expected 0 0 00000000", busy, done, result);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_mul;
    int lat, bc;
    applyStimulus(3'b000, 32'd7, 32'hFFFF_FFFD);
    waitDone(0, lat, bc);
    nChecks++;
    if (lat !== 32) begin
      nFails++;
      $display("[TB] FAIL mul_latency got %0d expected 32", lat);
    end
    nChecks++;
    if (bc !== 32) begin
      nFails++;
      $display("[TB] FAIL mul_busy_cycles got %0d expected 32", bc);
    end
    nChecks++;
    if (result !== 32'hFFFF_FFEB) begin
      nFails++;
      $display("[TB] FAIL mul_result got %h expected ffffffeb", result);
    end
    @(negedge clk);
    nChecks++;
    if (done !== 1'b0 || result !== 32'hFFFF_FFEB) begin
      nFails++;
      $display("[TB] FAIL mul_hold done=%b result=%h expected 0 ffffffeb", done, result);
    end
  endtask

  task automatic test_mulh;
    int lat, bc;
    applyStimulus(3'b001, 32'h8000_0000, 32'h8000_0000);
    waitDone(0, lat, bc);
    nChecks++;
    if (lat !== 32 || result !== 32'h4000_0000) begin
      nFails++;
      $display("[TB] FAIL mulh lat=%0d result=%h expected 32 40000000", lat, result);
    end
    @(negedge clk);
    applyStimulus(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    waitDone(0, lat, bc);
    nChecks++;
    if (lat !== 32 || result !== 32'hFFFF_FFFE) begin
      nFails++;
      $display("[TB] FAIL mulhu lat=%0d result=%h expected 32 fffffffe", lat, result);
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back;
    int lat, bc;
    applyStimulus(3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    waitDone(0, lat, bc);
    nChecks++;
    if (lat !== 32 || result !== 32'hFFFF_FFFF) begin
      nFails++;
      $display("[TB] FAIL mulhsu lat=%0d result=%h expected 32 ffffffff", lat, result);
    end
    // Still in the done cycle: the next request is taken at the coming edge.
    applyStimulus(3'b000, 32'd3, 32'd5);
    nChecks++;
    if (done !== 1'b0 || busy !== 1'b1) begin
      nFails++;
      $display("[TB] FAIL b2b_accept done=%b busy=%b expected 0 1", done, busy);
    end
    waitDone(0, lat, bc);
    nChecks++;
    if (lat !== 32 || result !== 32'h0000_000F) begin
      nFails++;
      $display("[TB] FAIL b2b_mul lat=%0d result=%h expected 32 0000000f", lat, result);
    end
    @(negedge clk);
  endtask

  task automatic test_ignore_start;
    int lat, bc;
    applyStimulus(3'b000, 32'd1000, 32'd2000);
    repeat (9) @(negedge clk);
    start   = 1'b1;
    funct3  = 3'b000;
    rs1_val = 32'd11;
    rs2_val = 32'd13;
    @(negedge clk);
    start   = 1'b0;
    waitDone(10, lat, bc);
    nChecks++;
    if (lat !== 32 || result !== 32'h001E_8480) begin
      nFails++;
      $display("[TB] FAIL ignore_start lat=%0d result=%h expected 32 001e8480", lat, result);
    end
    @(negedge clk);
    applyStimulus(3'b100, 32'd5, 32'd6);
    waitDone(0, lat, bc);
    nChecks++;
    if (lat !== 0 || bc !== 0 || result !== 32'h0) begin
      nFails++;
      $display("[TB] FAIL illegal_op lat=%0d busy_cycles=%0d result=%h expected 0 0 00000000", lat, bc, result);
    end
    @(negedge clk);
    nChecks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      nFails++;
      $display("[TB] FAIL illegal_after busy=%b done=%b expected 0 0", busy, done);
    end
  endtask

  task automatic test_reset_mid;
    int lat, bc, doneSeen;
    applyStimulus(3'b000, 32'd9, 32'd9);
    waitDone(0, lat, bc);
    @(negedge clk);
    applyStimulus(3'b000, 32'd4, 32'd4);
    repeat (15) @(negedge clk);
    rst_n = 1'b0;
    #1;
    nChecks++;
    if (busy !== 1'b0 || done !== 1'b0 || result !== 32'h0) begin
      nFails++;
      $display("[TB] FAIL reset_mid busy=%b done=%b result=%h expected 0 0 00000000", busy, done, result);
    end
    @(negedge clk);
    rst_n = 1'b1;
    doneSeen = 0;
    repeat (40) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) doneSeen++;
    end
    nChecks++;
    if (doneSeen !== 0) begin
      nFails++;
      $display("[TB] FAIL reset_discard active_cycles=%0d expected 0", doneSeen);
    end
    applyStimulus(3'b011, 32'd2, 32'd3);
    waitDone(0, lat, bc);
    nChecks++;
    if (lat !== 32 || result !== 32'h0) begin
      nFails++;
      $display("[TB] FAIL post_reset_mulhu lat=%0d result=%h expected 32 00000000", lat, result);
    end
    @(negedge clk);
  endtask

  task automatic test_zero_operand;
    int lat, bc;
    applyStimulus(3'b000, 32'd3, 32'd5);
    waitDone(0, lat, bc);
    @(negedge clk);
    applyStimulus(3'b000, 32'd12345, 32'd0);
    waitDone(0, lat, bc);
    nChecks++;
    if (lat !== ZERO_LAT || bc !== ZERO_BUSY) begin
      nFails++;
      $display("[TB] FAIL zero_latency lat=%0d busy_cycles=%0d expected %0d %0d", lat, bc, ZERO_LAT, ZERO_BUSY);
    end
    nChecks++;
    if (done !== 1'b1 || result !== 32'h0) begin
      nFails++;
      $display("[TB] FAIL zero_result done=%b result=%h expected 1 00000000", done, result);
    end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_mul();
    test_mulh();
    test_back_to_back();
    test_ignore_start();
    test_reset_mid();
    test_zero_operand();
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
